// File: rtl/ndma_burst_write_mgr.sv
// rtl/ndma_burst_write_mgr.sv - OBI burst write manager for the NanoDMA datapath
module ndma_burst_write_mgr #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [AW-1:0]    cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [DW-1:0]    wdata_i,
    output logic             obi_req_o,
    input  logic             obi_gnt_i,
    output logic [AW-1:0]    obi_addr_o,
    output logic             obi_we_o,
    output logic [DW/8-1:0]  obi_be_o,
    output logic [DW-1:0]    obi_wdata_o,
    input  logic             obi_rvalid_i,
    input  logic             obi_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [AW-1:0] STEP = AW'(DW / 8);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    cur_addr;
    logic [AW-1:0]    hold_addr;
    logic [DW-1:0]    hold_data;
    logic             hold_full;
    logic [LEN_W-1:0] beats_left;
    logic [LEN_W-1:0] resp_left;
    logic [OW-1:0]    outst_cnt;
    logic             err_q;

    logic             grant;
    logic             beat_acc;
    logic             rsp;
    logic             hold_full_nxt;
    logic [LEN_W-1:0] beats_left_nxt;
    logic [LEN_W-1:0] resp_left_nxt;

    // The holding register only changes on a grant, so a pending request stays stable.
    assign obi_req_o     = (state == BURST) && hold_full && (outst_cnt < OUTST_MAX);
    assign grant         = obi_req_o && obi_gnt_i;
    assign wdata_ready_o = (state == BURST) && (beats_left != '0) && (!hold_full || grant);
    assign beat_acc      = wdata_valid_i && wdata_ready_o;
    assign rsp           = obi_rvalid_i && (outst_cnt != '0);

    assign hold_full_nxt  = beat_acc || (hold_full && !grant);
    assign beats_left_nxt = beat_acc ? beats_left - LEN_W'(1) : beats_left;
    assign resp_left_nxt  = (rsp && (resp_left != '0)) ? resp_left - LEN_W'(1) : resp_left;

    assign obi_addr_o  = hold_addr;
    assign obi_wdata_o = hold_data;
    assign obi_we_o    = 1'b1;
    assign obi_be_o    = '1;
    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state == BURST) || (state == DRAIN);
    assign done_o      = (state == DONE);
    assign err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cur_addr   <= '0;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            beats_left <= '0;
            resp_left  <= '0;
            outst_cnt  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant && !rsp) begin
                outst_cnt <= outst_cnt + OW'(1);
            end else if (rsp && !grant) begin
                outst_cnt <= outst_cnt - OW'(1);
            end
            resp_left <= resp_left_nxt;
            if (rsp && obi_err_i) begin
                err_q <= 1'b1;
            end

            if (beat_acc) begin
                hold_data  <= wdata_i;
                hold_addr  <= cur_addr;
                hold_full  <= 1'b1;
                cur_addr   <= cur_addr + STEP;
                beats_left <= beats_left_nxt;
            end else if (grant) begin
                hold_full <= 1'b0;
            end

            // Transitions look at next-cycle counters so done follows the last rvalid by one cycle.
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cur_addr   <= cmd_addr_i;
                        beats_left <= cmd_len_i;
                        resp_left  <= cmd_len_i;
                        err_q      <= 1'b0;
                        state      <= (cmd_len_i == '0) ? DONE : BURST;
                    end
                end
                BURST: begin
                    if ((beats_left_nxt == '0) && !hold_full_nxt) begin
                        state <= (resp_left_nxt == '0) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (resp_left_nxt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
